// File: rtl/multicycle_adder_unit.sv
// Digit-serial adder/subtractor: DIGIT bits per clock over WIDTH/DIGIT cycles, result held until Run drops.
// Optional macro ACCUM_EN: on entry to DONE the new Sum is also written into the B register.
module multicycle_adder_unit #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             LoadB,
    input  logic             Run,
    input  logic             Sub,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] Bval,
    output logic [WIDTH-1:0] Sum,
    output logic             CO,
    output logic             OV,
    output logic             Busy,
    output logic             Done
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    generate
        if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("multicycle_adder_unit: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   part_q, part_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic               carry_q, carry_d;
    logic               co_q, co_d;
    logic               ov_q, ov_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    int                 bit_idx;
    logic [DIGIT-1:0]   dig_a, dig_b, dig_s;
    logic               dig_c;
    logic               bop_msb;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        carry_d = carry_q;
        co_d    = co_q;
        ov_d    = ov_q;

        // One digit slice of the ripple; subtract inverts B and seeds carry with 1
        bit_idx = int'(cnt_q) * DIGIT;
        dig_a   = a_q[bit_idx +: DIGIT];
        dig_b   = op_q ? ~b_q[bit_idx +: DIGIT] : b_q[bit_idx +: DIGIT];
        {dig_c, dig_s} = {1'b0, dig_a} + {1'b0, dig_b} + {{DIGIT{1'b0}}, carry_q};
        bop_msb = op_q ? ~b_q[WIDTH-1] : b_q[WIDTH-1];

        case (state_q)
            IDLE: begin
                if (Run) begin
                    a_d     = SW;
                    op_d    = Sub;
                    carry_d = Sub;
                    cnt_d   = '0;
                    part_d  = '0;
                    state_d = ADD;
                end else if (LoadB) begin
                    b_d = SW;
                end
            end
            ADD: begin
                part_d[bit_idx +: DIGIT] = dig_s;
                carry_d = dig_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    sum_d   = part_d;
                    co_d    = dig_c;
                    ov_d    = (a_q[WIDTH-1] == bop_msb) && (part_d[WIDTH-1] != a_q[WIDTH-1]);
`ifdef ACCUM_EN
                    b_d     = part_d;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!Run) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == ADD);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Bval = b_q;
    assign Sum  = sum_q;
    assign CO   = co_q;
    assign OV   = ov_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule
